// File: rtl/lane_unpacker.sv
// Lane unpacker: captures one packet of NUM_UNITS packed lanes and emits them one lane per handshake.
// Optional output parity (out_par) is enabled by defining LANE_UNPACKER_PARITY_EN.
module lane_unpacker #(
  parameter  int NUM_UNITS  = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int LW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] result_in,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0] operand_in,
  input  logic                            mode_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [LW-1:0]                   out_lane,
  output logic                            out_last,
  output logic                            out_raw
`ifdef LANE_UNPACKER_PARITY_EN
  ,
  output logic                            out_par
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam bit             RAW_OK   = (NUM_UNITS > 3);
  localparam logic [LW-1:0]  LAST_IDX = LW'(NUM_UNITS - 1);

  state_e                          state_q, state_d;
  logic [LW-1:0]                   cnt_q, cnt_d;
  logic [NUM_UNITS*DATA_WIDTH-1:0] result_q, result_d;
  logic [NUM_UNITS*DATA_WIDTH-1:0] operand_q, operand_d;
  logic                            mode_q, mode_d;

  logic [DATA_WIDTH-1:0]           lane_res_s;
  logic [DATA_WIDTH-1:0]           lane_op_s;
  logic                            is_last_s;
  logic                            raw_s;

  // State, lane counter and captured packet registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      operand_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      operand_q <= operand_d;
      mode_q    <= mode_d;
    end
  end

  // Current lane selection from the captured packet.
  always_comb begin
    lane_res_s = '0;
    lane_op_s  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (cnt_q == LW'(i)) begin
        lane_res_s = result_q[i*DATA_WIDTH +: DATA_WIDTH];
        lane_op_s  = operand_q[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        lane_res_s = lane_res_s;
        lane_op_s  = lane_op_s;
      end
    end
    is_last_s = (cnt_q == LAST_IDX);
    raw_s     = RAW_OK && mode_q && is_last_s;
  end

  // Next-state logic; in_ready is masked while rst is held so the reset view is all zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    operand_d = operand_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          result_d  = result_in;
          operand_d = operand_in;
          mode_d    = mode_in;
          cnt_d     = '0;
          state_d   = SEND;
        end else begin
          state_d   = IDLE;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_last_s) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + LW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane transform: even lanes subtract, odd lanes add, optional raw top lane.
  always_comb begin
    out_lane = '0;
    out_last = 1'b0;
    out_raw  = 1'b0;
    out_data = '0;
    if (state_q == SEND) begin
      out_lane = cnt_q;
      out_last = is_last_s;
      out_raw  = raw_s;
      if (raw_s) begin
        out_data = lane_res_s;
      end else if (cnt_q[0]) begin
        out_data = lane_res_s + lane_op_s;
      end else begin
        out_data = lane_res_s - lane_op_s;
      end
    end else begin
      out_data = '0;
    end
  end

`ifdef LANE_UNPACKER_PARITY_EN
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  assign out_par = out_valid & parity_of(out_data);
`endif

endmodule

// File: doc/lane_unpacker.md
LANE_UNPACKER -- requirements
Module: lane_unpacker

Interface
REQ-001 Parameter NUM_UNITS, default 4, is the number of packed lanes; legal values are NUM_UNITS >= 1.
REQ-002 Parameter DATA_WIDTH, default 8, is the width in bits of each lane.
REQ-003 Derived LW = max(1, $clog2(NUM_UNITS)) SHALL be the width of the lane index.
REQ-004 Clock is one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 in_valid  in  1  input packet valid.
REQ-008 in_ready  out  1  block accepts a packet.
REQ-009 result_in  in  NUM_UNITS*DATA_WIDTH  packed lane results; lane i occupies [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 operand_in  in  NUM_UNITS*DATA_WIDTH  packed operands, same lane layout.
REQ-011 mode_in  in  1  when set, the top lane carried a combined sum rather than a lane result.
REQ-012 out_valid  out  1  output lane valid.
REQ-013 out_ready  in  1  downstream accepts a lane.
REQ-014 out_data  out  DATA_WIDTH  recovered lane data.
REQ-015 out_lane  out  LW  index of the lane on out_data.
REQ-016 out_last  out  1  marks the final lane of a packet.
REQ-017 out_raw  out  1  out_data is passed through untransformed.

Function
REQ-018 The FSM SHALL have two states, IDLE and SEND; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in SEND.
REQ-019 When in_valid && in_ready, the block SHALL register result_in, operand_in and mode_in, clear the lane counter, and enter SEND on the next edge.
REQ-020 out_valid SHALL first assert in the cycle after acceptance (latency 1).
REQ-021 In SEND, out_lane SHALL equal the lane counter, and out_last SHALL be 1 when the counter equals NUM_UNITS-1.
REQ-022 For even lane k, out_data SHALL be result[k] - operand[k], modulo 2^DATA_WIDTH.
REQ-023 For odd lane k, out_data SHALL be result[k] + operand[k], modulo 2^DATA_WIDTH.
REQ-024 When the captured mode is 1 and NUM_UNITS > 3, lane NUM_UNITS-1 SHALL output the raw result with out_raw=1; in every other case out_raw SHALL be 0.
REQ-025 On out_valid && out_ready, the counter SHALL increment; on the last lane, the FSM SHALL return to IDLE.
REQ-026 in_ready SHALL assert the cycle after the last handshake; there is no same-cycle bypass.
REQ-027 While out_valid=1 && out_ready=0, out_data, out_lane, out_last and out_raw SHALL hold stable.
REQ-028 Input changes during SEND SHALL have no effect on outputs; in_valid in SEND SHALL be ignored and not lost silently, because in_ready=0.
REQ-029 With NUM_UNITS=1, a single beat SHALL be sent with out_last=1 and out_lane=0.

Reset
REQ-030 On rst, the FSM SHALL go to IDLE and the counter and captured registers SHALL clear to 0.
REQ-031 While in reset, outputs SHALL be: in_ready=0, out_valid=0, out_data=0, out_lane=0, out_last=0, out_raw=0.
REQ-032 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-033 Reset asserted in mid-packet SHALL discard the packet; no further lanes of it are emitted.

Configuration
REQ-034 Macro LANE_UNPACKER_PARITY_EN SHALL control output parity checking.
REQ-035 With LANE_UNPACKER_PARITY_EN defined, an extra output out_par (1 bit) SHALL equal the XOR-reduction of out_data whenever out_valid=1, and SHALL be 0 otherwise and in reset.
REQ-036 Without LANE_UNPACKER_PARITY_EN, port out_par SHALL be absent and all other behaviour SHALL be identical.

Verification (NUM_UNITS=4, DATA_WIDTH=8)
REQ-037 Basic: result lanes {0x05,0x10,0x40,0x07}, operand lanes {0x03,0x20,0x01,0x02}, mode=0, out_ready=1 -> four beats 0x02,0x30,0x3F,0x09, lanes 0..3, out_last on lane 3 only, in_ready high on the 5th cycle after acceptance.
REQ-038 Wrap: lane0 result 0x00, operand 0x01 and lane1 result 0xFF, operand 0x02 -> out_data 0xFF then 0x01.
REQ-039 Raw lane: mode=1, lane3 result 0xAB, operand 0x11 -> lane 3 out_data=0xAB with out_raw=1; lanes 0-2 have out_raw=0.
REQ-040 Backpressure: out_ready=0 for 3 cycles on lane 1 -> lane 1 outputs stable across the stall, and in_valid pulses with new data during SEND are not accepted.
REQ-041 Reset mid-packet: rst during lane 2 -> out_valid=0 immediately, in_ready=1 the cycle after release, and a new packet starts at lane 0.
REQ-042 Parity (macro defined): out_data 0x07 -> out_par=1; out_data 0x03 -> out_par=0.
